// File: rtl/basilisk.sv
// Shared scoreboard types: register address, dependency bundle and the
// hazard rule applied to a post-wakeup busy view.
package basilisk;

    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

    typedef struct packed {
        logic      use_rd;
        logic      use_rs1;
        logic      use_rs2;
        logic      use_rs3;
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rs3;
    } dep_t;

    // Unused operand fields never stall; rd is checked too so WAW is blocked.
    function automatic logic hazard_check(input logic [REG_COUNT-1:0] wake,
                                          input dep_t dep);
        return (dep.use_rs1 && wake[dep.rs1]) ||
               (dep.use_rs2 && wake[dep.rs2]) ||
               (dep.use_rs3 && wake[dep.rs3]) ||
               (dep.use_rd  && wake[dep.rd]);
    endfunction

endpackage

// File: rtl/basilisk_scoreboard_table.sv
// Per-register pending-write bits with issue-set and dual writeback clear,
// plus a wakeup view that already reflects this cycle's writebacks.
module basilisk_scoreboard_table
    import basilisk::*;
#(
    parameter int REG_COUNT = basilisk::REG_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en_i,
    input  reg_addr_t            set_addr_i,
    input  logic                 wb0_valid_i,
    input  reg_addr_t            wb0_addr_i,
    input  logic                 wb1_valid_i,
    input  reg_addr_t            wb1_addr_i,
    output logic [REG_COUNT-1:0] busy_o,
    output logic [REG_COUNT-1:0] wake_o
);

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic [REG_COUNT-1:0] clear, set;

    // A new issue wins over a writeback landing on the same register.
    always_comb begin
        clear = '0;
        set   = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            clear[i] = (wb0_valid_i && wb0_addr_i == reg_addr_t'(i)) ||
                       (wb1_valid_i && wb1_addr_i == reg_addr_t'(i));
            set[i]   = set_en_i && set_addr_i == reg_addr_t'(i);
        end
        busy_d = (busy_q & ~clear) | set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign wake_o = busy_q & ~clear;

    wb0_stray_a: assert property (@(posedge clk) disable iff (!rst)
        (wb0_valid_i && !(set_en_i && set_addr_i == wb0_addr_i)) |-> busy_q[wb0_addr_i])
        else $warning("stray writeback on wb0 to r%0d ignored", wb0_addr_i);

    wb1_stray_a: assert property (@(posedge clk) disable iff (!rst)
        (wb1_valid_i && !(set_en_i && set_addr_i == wb1_addr_i)) |-> busy_q[wb1_addr_i])
        else $warning("stray writeback on wb1 to r%0d ignored", wb1_addr_i);

endmodule

// File: rtl/basilisk_scoreboard.sv
// Float/vector issue scoreboard: stalls decode on RAW/WAW hazards and holds
// one registered issue slot towards execute.
module basilisk_scoreboard
    import basilisk::*;
#(
    parameter int REG_COUNT     = basilisk::REG_COUNT,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  reg_addr_t                in_rd,
    input  reg_addr_t                in_rs1,
    input  reg_addr_t                in_rs2,
    input  reg_addr_t                in_rs3,
    input  logic                     in_use_rd,
    input  logic                     in_use_rs1,
    input  logic                     in_use_rs2,
    input  logic                     in_use_rs3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    input  logic                     wb0_valid,
    input  reg_addr_t                wb0_addr,
    input  logic                     wb1_valid,
    input  reg_addr_t                wb1_addr,
    output logic [REG_COUNT-1:0]     busy,
    output logic                     idle
);

    logic [REG_COUNT-1:0]     wake;
    logic [basilisk::REG_COUNT-1:0] wake_full;
    logic                     hazard;
    logic                     fire;
    logic                     out_valid_q, out_valid_d;
    logic [PAYLOAD_WIDTH-1:0] out_payload_q, out_payload_d;
    dep_t                     dep;

    basilisk_scoreboard_table #(
        .REG_COUNT (REG_COUNT)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (fire && in_use_rd),
        .set_addr_i  (in_rd),
        .wb0_valid_i (wb0_valid),
        .wb0_addr_i  (wb0_addr),
        .wb1_valid_i (wb1_valid),
        .wb1_addr_i  (wb1_addr),
        .busy_o      (busy),
        .wake_o      (wake)
    );

    // Addresses reach all 32 slots, so unmapped registers read as never busy.
    for (genvar i = 0; i < basilisk::REG_COUNT; i++) begin : g_wake
        if (i < REG_COUNT) begin : g_map
            assign wake_full[i] = wake[i];
        end else begin : g_pad
            assign wake_full[i] = 1'b0;
        end
    end

    assign dep = '{use_rd: in_use_rd, use_rs1: in_use_rs1, use_rs2: in_use_rs2,
                   use_rs3: in_use_rs3, rd: in_rd, rs1: in_rs1, rs2: in_rs2, rs3: in_rs3};

    assign hazard   = hazard_check(wake_full, dep);
    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign fire     = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_payload_d = out_payload_q;
        if (fire) begin
            out_valid_d   = 1'b1;
            out_payload_d = in_payload;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_payload = out_payload_q;
    assign idle        = !(|busy) && !out_valid_q;

endmodule

// File: tb/tb_basilisk_scoreboard.sv
// Scoreboard bench: directed hazard/handshake/reset scenarios followed by
// random traffic, all checked against a set-of-pending-registers model.
module tb_basilisk_scoreboard;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_payload;
    logic [4:0]  in_rd, in_rs1, in_rs2, in_rs3;
    logic        in_use_rd, in_use_rs1, in_use_rs2, in_use_rs3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_payload;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] busy;
    logic        idle;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: the set of registers with a write in flight, and the
    // single issue slot towards execute.
    bit [31:0]   pending;
    bit          slotFull;
    logic [63:0] slotPayload;

    basilisk_scoreboard #(
        .REG_COUNT     (32),
        .PAYLOAD_WIDTH (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rs3      (in_rs3),
        .in_use_rd   (in_use_rd),
        .in_use_rs1  (in_use_rs1),
        .in_use_rs2  (in_use_rs2),
        .in_use_rs3  (in_use_rs3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .wb0_valid   (wb0_valid),
        .wb0_addr    (wb0_addr),
        .wb1_valid   (wb1_valid),
        .wb1_addr    (wb1_addr),
        .busy        (busy),
        .idle        (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input bit [3:0] uses,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rs3,
                                 input logic [63:0] payload);
        in_valid   = valid;
        {in_use_rd, in_use_rs1, in_use_rs2, in_use_rs3} = uses;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rs3     = rs3;
        in_payload = payload;
    endtask

    task automatic driveWriteback(input bit v0, input logic [4:0] a0,
                                  input bit v1, input logic [4:0] a1);
        wb0_valid = v0;
        wb0_addr  = a0;
        wb1_valid = v1;
        wb1_addr  = a1;
    endtask

    task automatic modelReset();
        pending     = '0;
        slotFull    = 1'b0;
        slotPayload = '0;
    endtask

    // One clock: check in_ready against the model, advance the model across
    // the edge, then check the registered outputs.
    task automatic runCycle();
        bit [31:0] freed;
        bit [31:0] stillPending;
        bit        stall;
        bit        expReady;
        bit        accepted;
        freed = '0;
        if (wb0_valid) freed[wb0_addr] = 1'b1;
        if (wb1_valid) freed[wb1_addr] = 1'b1;
        stillPending = pending & ~freed;
        stall = (in_use_rs1 && stillPending[in_rs1]) ||
                (in_use_rs2 && stillPending[in_rs2]) ||
                (in_use_rs3 && stillPending[in_rs3]) ||
                (in_use_rd  && stillPending[in_rd]);
        expReady = !stall && (!slotFull || out_ready);
        accepted = in_valid && expReady;
        #1;
        checkOutput("in_ready", in_ready, expReady);
        @(posedge clk);
        pending = stillPending;
        if (accepted && in_use_rd) pending[in_rd] = 1'b1;
        if (slotFull && out_ready) slotFull = 1'b0;
        if (accepted) begin
            slotFull    = 1'b1;
            slotPayload = in_payload;
        end
        #1;
        checkOutput("busy", busy, pending);
        checkOutput("out_valid", out_valid, slotFull);
        checkOutput("out_payload", out_payload, slotPayload);
        checkOutput("idle", idle, (pending == 0) && !slotFull);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        driveWriteback(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        logic [63:0] heldPayload;
        rst       = 1'b0;
        out_ready = 1'b1;
        idleInputs();
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 64'd0);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_idle", idle, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] fadd f3 = f1 + f2");
        applyStimulus(1'b1, 4'b1110, 5'd3, 5'd1, 5'd2, 5'd0, 64'hFADD_0003);
        runCycle();
        checkOutput("fadd_busy3", busy[3], 1'b1);
        checkOutput("fadd_idle", idle, 1'b0);

        $display("[TB] fmul f4 = f3 * f1 stalls until wb0 f3");
        applyStimulus(1'b1, 4'b1110, 5'd4, 5'd3, 5'd1, 5'd0, 64'hF0F0_0004);
        repeat (2) runCycle();
        checkOutput("fmul_stalled", out_payload, 64'hFADD_0003);
        driveWriteback(1'b1, 5'd3, 1'b0, 5'd0);
        runCycle();
        checkOutput("fmul_fired", out_payload, 64'hF0F0_0004);
        checkOutput("fmul_busy3", busy[3], 1'b0);
        checkOutput("fmul_busy4", busy[4], 1'b1);

        $display("[TB] execute back-pressure for 5 cycles");
        driveWriteback(1'b0, 5'd0, 1'b0, 5'd0);
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'b1100, 5'd10, 5'd11, 5'd0, 5'd0, 64'h0000_000A);
        heldPayload = out_payload;
        repeat (5) runCycle();
        checkOutput("hold_payload", out_payload, heldPayload);
        out_ready = 1'b1;
        runCycle();
        checkOutput("release_issue", out_payload, 64'h0000_000A);

        $display("[TB] dual writeback to f7");
        applyStimulus(1'b1, 4'b1000, 5'd7, 5'd0, 5'd0, 5'd0, 64'h0000_0007);
        runCycle();
        applyStimulus(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        driveWriteback(1'b1, 5'd7, 1'b1, 5'd7);
        runCycle();
        checkOutput("dual_wb_busy7", busy[7], 1'b0);
        driveWriteback(1'b1, 5'd4, 1'b1, 5'd10);
        runCycle();

        $display("[TB] issue f5 alongside wb1 f5");
        applyStimulus(1'b1, 4'b1000, 5'd5, 5'd0, 5'd0, 5'd0, 64'h0000_0005);
        driveWriteback(1'b0, 5'd0, 1'b1, 5'd5);
        runCycle();
        checkOutput("set_wins_busy5", busy[5], 1'b1);
        idleInputs();
        driveWriteback(1'b1, 5'd5, 1'b0, 5'd0);
        runCycle();
        idleInputs();
        runCycle();
        checkOutput("drained", busy, 64'd0);

        $display("[TB] asynchronous reset with work in flight");
        for (int r = 4; r < 8; r++) begin
            applyStimulus(1'b1, 4'b1000, 5'(r), 5'd0, 5'd0, 5'd0, 64'(32'hAB00 + r));
            runCycle();
        end
        idleInputs();
        out_ready = 1'b0;
        runCycle();
        checkOutput("pre_reset_busy", busy, 64'h0000_00F0);
        checkOutput("pre_reset_valid", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_busy", busy, 64'd0);
        checkOutput("async_out_valid", out_valid, 1'b0);
        checkOutput("async_payload", out_payload, 64'd0);
        checkOutput("async_idle", idle, 1'b1);
        modelReset();
        driveWriteback(1'b1, 5'd4, 1'b1, 5'd5);
        @(negedge clk);
        @(negedge clk);
        idleInputs();
        rst = 1'b1;
        out_ready = 1'b1;
        runCycle();

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            int pendList[$];
            bit v0, v1;
            logic [4:0] a0, a1;
            pendList.delete();
            for (int k = 0; k < 32; k++) if (pending[k]) pendList.push_back(k);
            v0 = 1'b0; v1 = 1'b0; a0 = 5'($urandom_range(31)); a1 = 5'($urandom_range(31));
            if (pendList.size() > 0 && $urandom_range(1) == 1) begin
                v0 = 1'b1;
                a0 = 5'(pendList[$urandom_range(pendList.size() - 1)]);
            end
            if (pendList.size() > 0 && $urandom_range(2) == 0) begin
                v1 = 1'b1;
                a1 = ($urandom_range(3) == 0) ? a0 : 5'(pendList[$urandom_range(pendList.size() - 1)]);
                if (!pending[a1]) a1 = 5'(pendList[0]);
            end
            driveWriteback(v0, a0, v1, a1);
            out_ready = ($urandom_range(3) != 0);
            applyStimulus($urandom_range(3) != 0, 4'($urandom_range(15)),
                          5'($urandom_range(31)), 5'($urandom_range(31)),
                          5'($urandom_range(31)), 5'($urandom_range(31)),
                          {$urandom, $urandom});
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
